// File: rtl/rv_fetch.sv
// Instruction prefetch unit: credit-based requests into a small in-order queue with redirect flush.
// Optional perf counters are compiled in with RV_FETCH_PERF_EN.
module rv_fetch #(
  parameter int         DEPTH    = 4,
  parameter logic [9:0] RESET_PC = 10'd0
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req_o,
  output logic [9:0]  imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_i,
  input  logic [9:0]  redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [9:0]  instr_pc_o,
  input  logic        instr_ready_i,
`ifdef RV_FETCH_PERF_EN
  output logic [31:0] perf_fetch_cnt_o,
  output logic [15:0] perf_flush_cnt_o,
`endif
  output logic [1:0]  dbg_state
);

  // Consumer handshake: the head moves on a cycle where instr_valid_o and instr_ready_i are both 1;
  // the head is held stable otherwise. Memory has no ready: data returns exactly one cycle after a request.

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          inflight;
  logic [9:0]    inflight_pc;
  logic [9:0]    fetch_pc;
  logic [31:0]   instr_mem [DEPTH];
  logic [9:0]    pc_mem    [DEPTH];

  logic [CW:0]   used;
  logic          credit;
  logic          req;
  logic          enq;
  logic          deq;

  // Inflight requests reserve a slot so the response always has room.
  assign used   = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign credit = (used < (CW+1)'(DEPTH));
  assign req    = (state_q == FETCH) && credit && !redirect_i;
  assign enq    = inflight && !redirect_i;
  assign deq    = instr_valid_o && instr_ready_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= BOOT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (!credit) state_d = HOLD;
      HOLD:    if (credit)  state_d = FETCH;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    imem_req_o  = req;
    imem_addr_o = req ? fetch_pc : 10'd0;
    dbg_state   = state_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 10'd0;
    end else begin
      inflight <= req;
      if (req) inflight_pc <= fetch_pc;
      if (redirect_i)  fetch_pc <= redirect_pc_i;
      else if (req)    fetch_pc <= fetch_pc + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (redirect_i) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) begin
        instr_mem[wr_ptr] <= imem_instr_i;
        pc_mem[wr_ptr]    <= inflight_pc;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      if (enq && !deq)      count <= count + CW'(1);
      else if (!enq && deq) count <= count - CW'(1);
    end
  end

  assign instr_valid_o = (count != '0);
  assign instr_o       = instr_mem[rd_ptr];
  assign instr_pc_o    = pc_mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(enq && !deq && count == CW'(DEPTH)));

`ifdef RV_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_fetch_cnt_o <= '0;
      perf_flush_cnt_o <= '0;
    end else begin
      if (deq)        perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
      if (redirect_i) perf_flush_cnt_o <= perf_flush_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv_fetch.sv
// Bench for rv_fetch: random and directed traffic checked cycle by cycle against a queue-based model.
// RESET_PC is set to 1022 so the address wrap is exercised straight out of reset.
module tb_rv_fetch;

  localparam int         DEPTH    = 4;
  localparam logic [9:0] RESET_PC = 10'd1022;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_req_o;
  logic [9:0]  imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        redirect_i;
  logic [9:0]  redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [9:0]  instr_pc_o;
  logic        instr_ready_i;
  logic [1:0]  dbg_state;
`ifdef RV_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [15:0] perf_flush_cnt_o;
`endif

  rv_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_instr_i  (imem_instr_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
`ifdef RV_FETCH_PERF_EN
    .perf_fetch_cnt_o (perf_fetch_cnt_o),
    .perf_flush_cnt_o (perf_flush_cnt_o),
`endif
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / memory ----------------
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return {a, ~a, 12'hA5C};
  endfunction

  always @(posedge clk) imem_instr_i <= mem_word(imem_addr_o);

  // ---------------- scoreboard / model state ----------------
  logic [9:0] exp_q[$];       // instruction addresses already written into the queue, oldest first
  bit         m_inflight;
  logic [9:0] m_inflight_pc;
  logic [9:0] m_pc;
  bit         m_boot;
  bit         m_fetch;
  int         m_hs;
  int         m_flush;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_inflight = 1'b0;
    m_inflight_pc = 10'd0;
    m_pc    = RESET_PC;
    m_boot  = 1'b1;
    m_fetch = 1'b0;
    m_hs    = 0;
    m_flush = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'd0, imem_req_o},    32'd0);
    check({tag, "_addr"},  {22'd0, imem_addr_o},   32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
    check({tag, "_instr"}, instr_o,                32'd0);
    check({tag, "_pc"},    {22'd0, instr_pc_o},    32'd0);
  endtask

  // Evaluated mid-cycle with the inputs that the next rising edge will see.
  task automatic model_eval();
    bit         exp_valid, credit, exp_req;
    logic [1:0] exp_state;
    if (!rstn) begin
      check_reset_outputs("rst_hold");
      model_reset();
      return;
    end
    exp_valid = (exp_q.size() != 0);
    credit    = (exp_q.size() + int'(m_inflight)) < DEPTH;
    exp_req   = !m_boot && m_fetch && credit && !redirect_i;
    exp_state = m_boot ? 2'd0 : (m_fetch ? 2'd1 : 2'd2);
    check("valid", {31'd0, instr_valid_o}, {31'd0, exp_valid});
    if (exp_valid) begin
      check("head_pc",    {22'd0, instr_pc_o}, {22'd0, exp_q[0]});
      check("head_instr", instr_o,             mem_word(exp_q[0]));
    end
    check("req",   {31'd0, imem_req_o}, {31'd0, exp_req});
    check("state", {30'd0, dbg_state},  {30'd0, exp_state});
    if (exp_req) check("req_addr", {22'd0, imem_addr_o}, {22'd0, m_pc});
`ifdef RV_FETCH_PERF_EN
    check("perf_fetch", perf_fetch_cnt_o,         m_hs);
    check("perf_flush", {16'd0, perf_flush_cnt_o}, m_flush);
`endif
    if (exp_valid && instr_ready_i) begin
      void'(exp_q.pop_front());
      m_hs++;
    end
    if (redirect_i) begin
      exp_q.delete();
      m_inflight = 1'b0;
      m_pc = redirect_pc_i;
      m_flush++;
    end else begin
      if (m_inflight) exp_q.push_back(m_inflight_pc);
      m_inflight = exp_req;
      if (exp_req) begin
        m_inflight_pc = m_pc;
        m_pc = m_pc + 10'd1;
      end
    end
    if (m_boot) begin
      m_boot  = 1'b0;
      m_fetch = 1'b1;
    end else if (m_fetch && !credit) m_fetch = 1'b0;
    else if (!m_fetch && credit)     m_fetch = 1'b1;
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit rdy, input bit rdr, input logic [9:0] rpc, input bit rst_val);
    @(posedge clk);
    #1;
    instr_ready_i = rdy;
    redirect_i    = rdr;
    redirect_pc_i = rpc;
    rstn          = rst_val;
    if (!rst_val) begin
      #1;
      check_reset_outputs("rst_async");
    end
    @(negedge clk);
    model_eval();
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(rdy, 1'b0, 10'd0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    rstn = 1'b0;
    instr_ready_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 10'd0;
    model_reset();
    #2;
    check_reset_outputs("por");
    check("por_state", {30'd0, dbg_state}, 32'd0);
    run(3, 1'b0);

    // Release with ready held: 1022, 1023, 0, 1 ...
    run(12, 1'b1);

    // Restart at 0 and stream.
    step(1'b1, 1'b1, 10'd0, 1'b1);
    run(10, 1'b1);

    // Stall: exactly DEPTH requests then HOLD; one dequeue reopens fetching.
    step(1'b0, 1'b1, 10'd0, 1'b1);
    run(10, 1'b0);
    check("full_cnt", exp_q.size(), DEPTH);
    step(1'b1, 1'b0, 10'd0, 1'b0 | 1'b1);
    run(6, 1'b0);

    // Flush with 3 queued and one inflight.
    step(1'b1, 1'b1, 10'd5, 1'b1);
    guard = 0;
    while (!(exp_q.size() == 3 && m_inflight) && guard < 20) begin
      step(1'b0, 1'b0, 10'd0, 1'b1);
      guard++;
    end
    check("flush_setup", {31'd0, (exp_q.size() == 3 && m_inflight)}, 32'd1);
    step(1'b0, 1'b1, 10'h200, 1'b1);
    run(6, 1'b1);

    // Back-to-back redirects: last target wins.
    step(1'b1, 1'b1, 10'h100, 1'b1);
    step(1'b1, 1'b1, 10'h300, 1'b1);
    run(6, 1'b1);

    // Reset mid-stream with queued entries.
    guard = 0;
    while (exp_q.size() < 2 && guard < 20) begin
      step(1'b0, 1'b0, 10'd0, 1'b1);
      guard++;
    end
    check("rst_setup", {31'd0, exp_q.size() >= 2}, 32'd1);
    step(1'b0, 1'b0, 10'd0, 1'b0);
    step(1'b1, 1'b0, 10'd0, 1'b0);
    run(10, 1'b1);

    // Exact perf scenario: 10 handshakes and 2 redirects from a fresh reset.
    step(1'b0, 1'b0, 10'd0, 1'b0);
    guard = 0;
    while (m_hs < 10 && guard < 40) begin
      step(m_hs < 9 || exp_q.size() != 0, (guard == 3 || guard == 7), 10'd20, 1'b1);
      guard++;
    end
    run(2, 1'b0);
    check("perf_hs_model", m_hs, 10);
`ifdef RV_FETCH_PERF_EN
    check("perf_fetch_10", perf_fetch_cnt_o, 32'd10);
    check("perf_flush_2",  {16'd0, perf_flush_cnt_o}, 32'd2);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           ($urandom_range(0, 3) == 0) ? 10'd1023 : 10'($urandom_range(0, 1023)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
